// File: rtl/vector_dot_reader_if.sv
// Bundles the vector-store read port and the result valid/ready handshake of
// the dot-product reader.
interface vector_dot_reader_if #(
  parameter int unsigned W     = 8,
  parameter int unsigned ACC_W = 19
);
  logic             start;
  logic             doneA;
  logic             doneB;
  logic [W-1:0]     readDataA;
  logic [W-1:0]     readDataB;
  logic             RD_EN;
  logic             busy;
  logic [ACC_W-1:0] result;
  logic             result_valid;
  logic             result_ready;

  modport master (
    input  start, doneA, doneB, readDataA, readDataB, result_ready,
    output RD_EN, busy, result, result_valid
  );

  modport slave (
    output start, doneA, doneB, readDataA, readDataB, result_ready,
    input  RD_EN, busy, result, result_valid
  );
endinterface

// File: rtl/vector_dot_reader.sv
// Reads N A/B element pairs from the vector store, multiply-accumulates them and
// offers the unsigned dot product on a valid/ready handshake.
module vector_dot_reader #(
  parameter int unsigned N     = 8,
  parameter int unsigned W     = 8,
  parameter int unsigned ACC_W = 19
) (
  input logic                 CLK,
  input logic                 RST,
  vector_dot_reader_if.master bus_io
);

  localparam int unsigned CntW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {StIdle, StRead, StDrain, StHold} state_e;

  state_e             state_q, state_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [ACC_W-1:0]   result_q, result_d;
  logic               valid_q, valid_d;
  logic               rd_q;
  logic               rd_en;
  logic [2*W-1:0]     prod;
  logic [ACC_W-1:0]   prod_ext;

  assign prod     = {{W{1'b0}}, bus_io.readDataA} * {{W{1'b0}}, bus_io.readDataB};
  assign prod_ext = {{(ACC_W - 2 * W){1'b0}}, prod};

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      acc_q    <= '0;
      result_q <= '0;
      valid_q  <= 1'b0;
      rd_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      valid_q  <= valid_d;
      rd_q     <= rd_en;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    result_d = result_q;
    valid_d  = valid_q;
    // Store data lags RD_EN by one cycle, so accumulation follows rd_q.
    if (rd_q) begin
      acc_d = acc_q + prod_ext;
    end
    unique case (state_q)
      StIdle: begin
        if (bus_io.start && bus_io.doneA && bus_io.doneB) begin
          state_d = StRead;
          cnt_d   = '0;
          acc_d   = '0;
        end
      end
      StRead: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CntW'(N - 1)) begin
          state_d = StDrain;
        end
      end
      StDrain: begin
        // Publish only once the last product has landed in acc_q.
        if (!rd_q) begin
          state_d  = StHold;
          result_d = acc_q;
          valid_d  = 1'b1;
        end
      end
      StHold: begin
        if (bus_io.result_ready) begin
          state_d = StIdle;
          valid_d = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    rd_en               = (state_q == StRead);
    bus_io.RD_EN        = rd_en;
    bus_io.busy         = (state_q == StRead) || (state_q == StDrain);
    bus_io.result       = result_q;
    bus_io.result_valid = valid_q;
  end

endmodule

// File: tb/tb_vector_dot_reader.sv
// Directed bench for vector_dot_reader with a behavioural 8-deep A/B store
// whose read pointer wraps, so read order across runs is observable.
module tb_vector_dot_reader;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  logic [7:0]  mem_a [8];
  logic [7:0]  mem_b [8];
  logic [2:0]  ptr;
  logic [23:0] idx_log;

  vector_dot_reader_if #(.W(8), .ACC_W(19)) bus ();

  vector_dot_reader #(.N(8), .W(8), .ACC_W(19)) dut (
    .CLK    (clk),
    .RST    (rst),
    .bus_io (bus)
  );

  always #5 clk = ~clk;

  // Registered-read store model; reset together with the reader.
  always @(posedge clk) begin
    if (rst) begin
      ptr           <= '0;
      bus.readDataA <= '0;
      bus.readDataB <= '0;
      idx_log       <= '0;
    end else if (bus.RD_EN) begin
      bus.readDataA <= mem_a[ptr];
      bus.readDataB <= mem_b[ptr];
      idx_log       <= {ptr, idx_log[23:3]};
      ptr           <= ptr + 3'd1;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  // mode 0: A=1..8 B=1, mode 1: A=B=255, mode 2: A=1..8 B=8..1
  task automatic load(input int mode);
    for (int i = 0; i < 8; i++) begin
      case (mode)
        0:       begin mem_a[i] = 8'(i + 1); mem_b[i] = 8'd1;       end
        1:       begin mem_a[i] = 8'd255;    mem_b[i] = 8'd255;     end
        default: begin mem_a[i] = 8'(i + 1); mem_b[i] = 8'(8 - i);  end
      endcase
    end
  endtask

  task automatic pulse_start();
    @(negedge clk);
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  // Starts a run and checks RD_EN window, valid latency, result, optional hold.
  task automatic run_check(input string tag, input int exp_res, input int hold_cycles);
    int rd_cnt   = 0;
    int first_rd = -1;
    int last_rd  = -1;
    int valid_at = -1;
    bus.result_ready = (hold_cycles == 0);
    pulse_start();
    check_eq({tag, ".busy"}, 32'(bus.busy), 32'd1);
    for (int k = 1; k <= 30 && valid_at < 0; k++) begin
      if (bus.RD_EN) begin
        rd_cnt++;
        if (first_rd < 0) first_rd = k;
        last_rd = k;
      end
      @(posedge clk);
      #1;
      if (bus.result_valid) valid_at = k;
    end
    check_eq({tag, ".rd_cnt"},   32'(rd_cnt),     32'd8);
    check_eq({tag, ".first_rd"}, 32'(first_rd),   32'd1);
    check_eq({tag, ".last_rd"},  32'(last_rd),    32'd8);
    check_eq({tag, ".valid_at"}, 32'(valid_at),   32'd10);
    check_eq({tag, ".result"},   32'(bus.result), 32'(exp_res));
    check_eq({tag, ".rd_order"}, 32'(idx_log),    32'(24'o76543210));
    for (int h = 0; h < hold_cycles; h++) begin
      @(posedge clk);
      #1;
      check_eq({tag, ".hold_valid"},  32'(bus.result_valid), 32'd1);
      check_eq({tag, ".hold_result"}, 32'(bus.result),       32'(exp_res));
    end
    if (hold_cycles != 0) begin
      bus.start        = 1'b1;
      bus.result_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      check_eq({tag, ".accept_valid"}, 32'(bus.result_valid), 32'd0);
      check_eq({tag, ".accept_rd"},    32'(bus.RD_EN),        32'd0);
    end else begin
      @(posedge clk);
      #1;
      check_eq({tag, ".drop_valid"}, 32'(bus.result_valid), 32'd0);
    end
    check_eq({tag, ".idle_busy"},   32'(bus.busy),   32'd0);
    check_eq({tag, ".keep_result"}, 32'(bus.result), 32'(exp_res));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start        = 1'b0;
    bus.doneA        = 1'b1;
    bus.doneB        = 1'b1;
    bus.result_ready = 1'b1;
    load(0);
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst.rd_en",  32'(bus.RD_EN),        32'd0);
    check_eq("rst.busy",   32'(bus.busy),         32'd0);
    check_eq("rst.result", 32'(bus.result),       32'd0);
    check_eq("rst.valid",  32'(bus.result_valid), 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    run_check("ramp_x1", 36, 0);

    load(1);
    run_check("max", 520200, 0);

    bus.doneB = 1'b0;
    for (int p = 0; p < 3; p++) begin
      pulse_start();
      check_eq("noB.rd_en", 32'(bus.RD_EN),        32'd0);
      check_eq("noB.busy",  32'(bus.busy),         32'd0);
      check_eq("noB.valid", 32'(bus.result_valid), 32'd0);
    end
    bus.doneB = 1'b1;
    run_check("afterB", 520200, 0);

    load(2);
    run_check("hold", 120, 5);
    run_check("b2b_1", 120, 0);
    run_check("b2b_2", 120, 0);

    pulse_start();
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_eq("midrst.rd_en",  32'(bus.RD_EN),        32'd0);
    check_eq("midrst.busy",   32'(bus.busy),         32'd0);
    check_eq("midrst.result", 32'(bus.result),       32'd0);
    check_eq("midrst.valid",  32'(bus.result_valid), 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    run_check("recover", 120, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
